// File: rtl/mem_resp_pkg.sv
// Shared definitions for the multi-cycle memory responder: FSM state
// encoding, default access latency, data width and latency-counter width.
package mem_resp_pkg;

  localparam int DATA_W          = 16;
  localparam int MEM_LATENCY_DEF = 4;
  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for the memory responder: 2^ADDR_W x DATA_W words with one
// combinational read port and one synchronous write port. Contents are not
// reset; software/bench initialises memory through stores.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Commit a store on the rising edge when the write enable is set.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder. Accepts one load/store at a time over a
// valid/ready handshake and answers after a fixed LATENCY (1..15) cycles.
// Stores commit and load data is captured at accept, so the response
// registers only need to be held until the requester takes them.
// Optional build macro: MEM_RESP_ALIGN_CHK_EN enables the misaligned-access
// check (odd byte address -> no write, zero read data, rsp_err set).
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY_DEF,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  // With a one-cycle latency the accept edge leads straight to RESP.
  localparam bit DIRECT_RESP = (LATENCY == 1);

  state_e            state_r;
  state_e            state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic              rsp_wr_r;
  logic              rsp_err_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic [DATA_W-1:0] rd_word_s;
  logic [ADDR_W-1:0] word_idx_s;
  logic              accept_s;
  logic              misalign_s;
  logic              mem_we_s;
  logic              addr_unused_s;

  // Byte address to word index; bits above ADDR_W are dropped so addresses wrap.
  assign word_idx_s = req_addr[ADDR_W:1];
  // Upper address bits (and bit 0 without the alignment check) carry no meaning.
  assign addr_unused_s = ^req_addr;

`ifdef MEM_RESP_ALIGN_CHK_EN
  assign misalign_s = req_addr[0];
`else
  assign misalign_s = 1'b0;
`endif

  // req_ready_r is high exactly in IDLE, so this is the handshake.
  assign accept_s = req_valid & req_ready_r;
  // Reset wins over accept: no storage write while rst_n is low.
  assign mem_we_s = rst_n & accept_s & req_wr & ~misalign_s;

  mem_resp_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (word_idx_s),
    .wdata (req_wdata),
    .raddr (word_idx_s),
    .rdata (rd_word_s)
  );

  // State, latency counter and the registered handshake flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      req_ready_r <= (state_s == IDLE);
      rsp_valid_r <= (state_s == RESP);
    end
  end

  // Next-state and counter logic: IDLE -> BUSY (count down) -> RESP -> IDLE.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          cnt_s = LAT_M1;
          if (DIRECT_RESP) begin
            state_s = RESP;
          end else begin
            state_s = BUSY;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r > CNT_ONE) begin
          cnt_s   = cnt_r - CNT_ONE;
          state_s = BUSY;
        end else begin
          cnt_s   = CNT_ZERO;
          state_s = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Capture the response payload at accept and hold it until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_wr_r    <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      rsp_wr_r  <= req_wr;
      rsp_err_r <= misalign_s;
      if (req_wr || misalign_s) begin
        rsp_rdata_r <= {DATA_W{1'b0}};
      end else begin
        rsp_rdata_r <= rd_word_s;
      end
    end else begin
      rsp_wr_r    <= rsp_wr_r;
      rsp_err_r   <= rsp_err_r;
      rsp_rdata_r <= rsp_rdata_r;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_wr    = rsp_wr_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Two instances (LATENCY=4 and
// LATENCY=1) are checked against a word-array reference model that applies
// the access rules directly (commit at accept, address wrap, alignment).
module tb_mem_responder;

  localparam int LAT0   = 4;
  localparam int LAT1   = 1;
  localparam int ADDR_W = 10;
`ifdef MEM_RESP_ALIGN_CHK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wr    [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic        rsp_wr    [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int total = 0;
  int bad   = 0;

  logic [15:0] model [2][2**ADDR_W];
  bit          known [2][2**ADDR_W];

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(LAT0), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_wr(rsp_wr[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.LATENCY(LAT1), .ADDR_W(ADDR_W)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_wr(rsp_wr[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int lat_of(input int s);
    return (s == 0) ? LAT0 : LAT1;
  endfunction

  // Reference model: apply one accepted request, return the expected response.
  task automatic model_apply(input int s, input bit wr, input logic [15:0] addr,
                             input logic [15:0] wdata, output logic [15:0] e_rd,
                             output logic e_err, output bit e_chk);
    bit mis;
    int idx;
    mis   = ALIGN_ON && addr[0];
    idx   = int'(addr[ADDR_W:1]);
    e_err = mis;
    e_chk = 1'b1;
    if (wr) begin
      e_rd = 16'h0000;
      if (!mis) begin
        model[s][idx] = wdata;
        known[s][idx] = 1'b1;
      end
    end else if (mis) begin
      e_rd = 16'h0000;
    end else begin
      e_rd  = model[s][idx];
      e_chk = known[s][idx];
    end
  endtask

  // Drive one transaction (called at #1 after an edge, DUT idle) and report observations.
  task automatic do_txn(input int s, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input int hold,
                        output int lat_obs, output logic [15:0] rd_obs,
                        output logic wr_obs, output logic err_obs,
                        output bit stable_ok, output bit ready_after);
    lat_obs     = -1;
    rd_obs      = 16'h0000;
    wr_obs      = 1'b0;
    err_obs     = 1'b0;
    stable_ok   = 1'b1;
    ready_after = 1'b0;
    req_valid[s] = 1'b1;
    req_wr[s]    = wr;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    rsp_ready[s] = (hold == 0);
    @(posedge clk); #1;
    for (int c = 1; c <= 40; c++) begin
      req_valid[s] = 1'($urandom);
      req_wr[s]    = 1'($urandom);
      req_addr[s]  = 16'($urandom);
      req_wdata[s] = 16'($urandom);
      if (rsp_valid[s] === 1'b1) begin
        lat_obs = c;
        break;
      end
      if (req_ready[s] !== 1'b0) stable_ok = 1'b0;
      @(posedge clk); #1;
    end
    if (lat_obs < 0) begin
      req_valid[s] = 1'b0;
      return;
    end
    rd_obs  = rsp_rdata[s];
    wr_obs  = rsp_wr[s];
    err_obs = rsp_err[s];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (rsp_valid[s] !== 1'b1 || rsp_rdata[s] !== rd_obs || rsp_wr[s] !== wr_obs ||
          rsp_err[s] !== err_obs || req_ready[s] !== 1'b0) stable_ok = 1'b0;
    end
    rsp_ready[s] = 1'b1;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    rsp_ready[s] = 1'b0;
    ready_after  = (req_ready[s] === 1'b1) && (rsp_valid[s] === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      total++;
      if (req_ready[s] !== 1'b1) begin bad++; $display("FAIL reset_req_ready[%0d]: got %b want 1", s, req_ready[s]); end
      total++;
      if (rsp_valid[s] !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid[%0d]: got %b want 0", s, rsp_valid[s]); end
      total++;
      if (rsp_rdata[s] !== 16'h0000) begin bad++; $display("FAIL reset_rsp_rdata[%0d]: got %h want 0000", s, rsp_rdata[s]); end
      total++;
      if (rsp_wr[s] !== 1'b0 || rsp_err[s] !== 1'b0) begin bad++; $display("FAIL reset_wr_err[%0d]: got %b%b want 00", s, rsp_wr[s], rsp_err[s]); end
    end
  endtask

  task automatic test_store_load();
    int lat; logic [15:0] rd; logic w, er; bit st, ra; logic [15:0] e_rd; logic e_err; bit e_chk;
    model_apply(0, 1'b1, 16'h0010, 16'hBEEF, e_rd, e_err, e_chk);
    do_txn(0, 1'b1, 16'h0010, 16'hBEEF, 0, lat, rd, w, er, st, ra);
    total++;
    if (lat != LAT0) begin bad++; $display("FAIL sl_store_lat: got %0d want %0d", lat, LAT0); end
    total++;
    if (w !== 1'b1 || rd !== 16'h0000) begin bad++; $display("FAIL sl_store_rsp: got wr=%b rd=%h want wr=1 rd=0000", w, rd); end
    total++;
    if (ra !== 1'b1) begin bad++; $display("FAIL sl_store_ready_after: got %b want 1", ra); end
    model_apply(0, 1'b0, 16'h0010, 16'h0000, e_rd, e_err, e_chk);
    do_txn(0, 1'b0, 16'h0010, 16'h0000, 0, lat, rd, w, er, st, ra);
    total++;
    if (lat != LAT0) begin bad++; $display("FAIL sl_load_lat: got %0d want %0d", lat, LAT0); end
    total++;
    if (rd !== 16'hBEEF || w !== 1'b0) begin bad++; $display("FAIL sl_load_data: got rd=%h wr=%b want rd=beef wr=0", rd, w); end
  endtask

  task automatic test_backpressure();
    int lat; logic [15:0] rd; logic w, er; bit st, ra; logic [15:0] e_rd; logic e_err; bit e_chk;
    model_apply(0, 1'b0, 16'h0010, 16'h0000, e_rd, e_err, e_chk);
    do_txn(0, 1'b0, 16'h0010, 16'h0000, 6, lat, rd, w, er, st, ra);
    total++;
    if (st !== 1'b1) begin bad++; $display("FAIL bp_stable: got %b want 1", st); end
    total++;
    if (rd !== 16'hBEEF) begin bad++; $display("FAIL bp_rdata: got %h want beef", rd); end
    total++;
    if (ra !== 1'b1) begin bad++; $display("FAIL bp_ready_after: got %b want 1", ra); end
  endtask

  task automatic test_addr_wrap();
    int lat; logic [15:0] rd; logic w, er; bit st, ra; logic [15:0] e_rd; logic e_err; bit e_chk;
    model_apply(1, 1'b1, 16'h0802, 16'h1234, e_rd, e_err, e_chk);
    do_txn(1, 1'b1, 16'h0802, 16'h1234, 0, lat, rd, w, er, st, ra);
    total++;
    if (lat != LAT1) begin bad++; $display("FAIL wrap_store_lat1: got %0d want %0d", lat, LAT1); end
    model_apply(1, 1'b0, 16'h0002, 16'h0000, e_rd, e_err, e_chk);
    do_txn(1, 1'b0, 16'h0002, 16'h0000, 2, lat, rd, w, er, st, ra);
    total++;
    if (rd !== 16'h1234) begin bad++; $display("FAIL wrap_load_data: got %h want 1234", rd); end
    total++;
    if (lat != LAT1 || st !== 1'b1 || ra !== 1'b1) begin bad++; $display("FAIL wrap_load_lat1: got lat=%0d st=%b ra=%b want lat=%0d st=1 ra=1", lat, st, ra, LAT1); end
  endtask

  task automatic test_align();
    int lat; logic [15:0] rd; logic w, er; bit st, ra; logic [15:0] e_rd; logic e_err; bit e_chk;
    logic [15:0] want;
    model_apply(0, 1'b1, 16'h0010, 16'hA5A5, e_rd, e_err, e_chk);
    do_txn(0, 1'b1, 16'h0010, 16'hA5A5, 0, lat, rd, w, er, st, ra);
    model_apply(0, 1'b1, 16'h0011, 16'h5A5A, e_rd, e_err, e_chk);
    do_txn(0, 1'b1, 16'h0011, 16'h5A5A, 1, lat, rd, w, er, st, ra);
    total++;
    if (er !== ALIGN_ON) begin bad++; $display("FAIL align_store_err: got %b want %b", er, ALIGN_ON); end
    total++;
    if (lat != LAT0 || w !== 1'b1 || rd !== 16'h0000) begin bad++; $display("FAIL align_store_rsp: got lat=%0d wr=%b rd=%h want lat=%0d wr=1 rd=0000", lat, w, rd, LAT0); end
    want = ALIGN_ON ? 16'hA5A5 : 16'h5A5A;
    model_apply(0, 1'b0, 16'h0010, 16'h0000, e_rd, e_err, e_chk);
    do_txn(0, 1'b0, 16'h0010, 16'h0000, 0, lat, rd, w, er, st, ra);
    total++;
    if (rd !== want || er !== 1'b0) begin bad++; $display("FAIL align_reload: got rd=%h err=%b want rd=%h err=0", rd, er, want); end
    want = ALIGN_ON ? 16'h0000 : 16'h5A5A;
    model_apply(0, 1'b0, 16'h0011, 16'h0000, e_rd, e_err, e_chk);
    do_txn(0, 1'b0, 16'h0011, 16'h0000, 0, lat, rd, w, er, st, ra);
    total++;
    if (rd !== want || er !== ALIGN_ON) begin bad++; $display("FAIL align_load: got rd=%h err=%b want rd=%h err=%b", rd, er, want, ALIGN_ON); end
  endtask

  task automatic test_reset_mid_busy();
    int lat; logic [15:0] rd; logic w, er; bit st, ra; logic [15:0] e_rd; logic e_err; bit e_chk;
    bit rose;
    model_apply(0, 1'b1, 16'h0040, 16'hC0DE, e_rd, e_err, e_chk);
    do_txn(0, 1'b1, 16'h0040, 16'hC0DE, 0, lat, rd, w, er, st, ra);
    // accept a load, then reset in cycle 2
    req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = 16'h0040; rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin bad++; $display("FAIL midrst_flags: got ready=%b valid=%b want 1 0", req_ready[0], rsp_valid[0]); end
    total++;
    if (rsp_rdata[0] !== 16'h0000 || rsp_wr[0] !== 1'b0 || rsp_err[0] !== 1'b0) begin bad++; $display("FAIL midrst_payload: got rd=%h wr=%b err=%b want 0", rsp_rdata[0], rsp_wr[0], rsp_err[0]); end
    rose = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid[0] !== 1'b0) rose = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (rose) begin bad++; $display("FAIL midrst_no_rsp: got rsp_valid rise want none"); end
    // a store presented during reset must not be accepted or written
    rst_n = 1'b0;
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 16'h0040; req_wdata[0] = 16'hDEAD;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid[0] = 1'b0;
    // a store accepted just before reset stays committed
    model_apply(0, 1'b1, 16'h0042, 16'h7777, e_rd, e_err, e_chk);
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 16'h0042; req_wdata[0] = 16'h7777;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_apply(0, 1'b0, 16'h0040, 16'h0000, e_rd, e_err, e_chk);
    do_txn(0, 1'b0, 16'h0040, 16'h0000, 0, lat, rd, w, er, st, ra);
    total++;
    if (rd !== 16'hC0DE || lat != LAT0) begin bad++; $display("FAIL midrst_reload: got rd=%h lat=%0d want c0de lat=%0d", rd, lat, LAT0); end
    model_apply(0, 1'b0, 16'h0042, 16'h0000, e_rd, e_err, e_chk);
    do_txn(0, 1'b0, 16'h0042, 16'h0000, 0, lat, rd, w, er, st, ra);
    total++;
    if (rd !== 16'h7777) begin bad++; $display("FAIL midrst_committed: got %h want 7777", rd); end
  endtask

  task automatic test_random();
    int lat; logic [15:0] rd; logic w, er; bit st, ra; logic [15:0] e_rd; logic e_err; bit e_chk;
    logic [15:0] addr, wdata; bit wr; int hold;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        addr  = 16'(i << 1);
        wdata = 16'($urandom);
        model_apply(s, 1'b1, addr, wdata, e_rd, e_err, e_chk);
        do_txn(s, 1'b1, addr, wdata, 0, lat, rd, w, er, st, ra);
      end
      for (int n = 0; n < 40; n++) begin
        addr  = 16'($urandom) & 16'hF81F;
        wdata = 16'($urandom);
        wr    = 1'($urandom);
        hold  = $urandom_range(0, 3);
        model_apply(s, wr, addr, wdata, e_rd, e_err, e_chk);
        do_txn(s, wr, addr, wdata, hold, lat, rd, w, er, st, ra);
        total++;
        if (lat != lat_of(s) || w !== wr || er !== e_err || st !== 1'b1 || ra !== 1'b1) begin
          bad++;
          $display("FAIL rnd_ctrl[%0d.%0d]: got lat=%0d wr=%b err=%b st=%b ra=%b want lat=%0d wr=%b err=%b st=1 ra=1",
                   s, n, lat, w, er, st, ra, lat_of(s), wr, e_err);
        end
        if (e_chk) begin
          total++;
          if (rd !== e_rd) begin bad++; $display("FAIL rnd_rdata[%0d.%0d]: addr=%h got %h want %h", s, n, addr, rd, e_rd); end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_wr[s]    = 1'b0;
      req_addr[s]  = 16'h0000;
      req_wdata[s] = 16'h0000;
      rsp_ready[s] = 1'b0;
      for (int i = 0; i < 2**ADDR_W; i++) begin
        known[s][i] = 1'b0;
        model[s][i] = 16'h0000;
      end
    end
    test_reset();
    test_store_load();
    test_backpressure();
    test_addr_wrap();
    test_align();
    test_reset_mid_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
